// File: rtl/fetch_npc.sv
// fetch_npc: fetch-stage PC register, IF/ID latch and next-PC selection.
// Decodes the instruction held in IF/ID to redirect fetch for
// beq/bgezal/bltz/j/jal/jr/jalr.
// Optional feature macro: NPC_DELAY_SLOT_EN
//   defined   -> MIPS delay-slot semantics; a taken transfer never flushes IF/ID
//   undefined -> a taken transfer replaces the next IF/ID entry with a nop
module fetch_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic        cmpout,
  input  logic [31:0] rs_d,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        redirect
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic        is_branch;
  logic        is_jump;
  logic        is_jreg;
  logic        taken_branch;
  logic [31:0] imm_ext;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] pc_next;
  logic        flush;

  assign op    = instr_d[31:26];
  assign rt    = instr_d[20:16];
  assign funct = instr_d[5:0];

  // Classify the instruction sitting in IF/ID; cmpout only matters for branches.
  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_jreg   = 1'b0;
    case (op)
      OP_BEQ:     is_branch = 1'b1;
      OP_REGIMM:  is_branch = (rt == RT_BGEZAL) || (rt == RT_BLTZ);
      OP_J,
      OP_JAL:     is_jump   = 1'b1;
      OP_SPECIAL: is_jreg   = (funct == FN_JR) || (funct == FN_JALR);
      default: ;
    endcase
  end

  assign taken_branch  = is_branch && cmpout;
  assign redirect      = taken_branch || is_jump || is_jreg;
  assign imm_ext       = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign branch_target = pc_d + 32'd4 + imm_ext;
  assign jump_target   = {pc_d[31:28], instr_d[25:0], 2'b00};

  // Next-PC select; taken branch outranks jumps, which outrank register jumps.
  always_comb begin
    pc_next = pc_f + 32'd4;
    if (taken_branch)
      pc_next = branch_target;
    else if (is_jump)
      pc_next = jump_target;
    else if (is_jreg)
      pc_next = rs_d;
  end

`ifdef NPC_DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = redirect;
`endif

  // PC and IF/ID latch; reset beats stall, stall freezes everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f    <= RESET_PC;
      instr_d <= 32'h0;
      pc_d    <= 32'h0;
      pc8_d   <= 32'h0;
    end else if (!stall) begin
      pc_f    <= pc_next;
      instr_d <= flush ? 32'h0 : instr_f;
      pc_d    <= pc_f;
      pc8_d   <= pc_f + 32'd8;
    end
  end

endmodule

// File: tb/tb_fetch_npc.sv
// tb_fetch_npc: scoreboard bench for fetch_npc. A behavioural model predicts
// the post-edge state for every driven cycle; predictions are queued and
// compared once the DUT has clocked.
module tb_fetch_npc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instr_f;
  logic        cmpout;
  logic [31:0] rs_d;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        redirect;

  fetch_npc dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .instr_f  (instr_f),
    .cmpout   (cmpout),
    .rs_d     (rs_d),
    .pc_f     (pc_f),
    .instr_d  (instr_d),
    .pc_d     (pc_d),
    .pc8_d    (pc8_d),
    .redirect (redirect)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc8;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
  bit          m_valid = 0;

  localparam logic [31:0] I_BEQ_M1  = 32'h1000_FFFF;
  localparam logic [31:0] I_JAL     = 32'h0C00_0C40;
  localparam logic [31:0] I_JR      = 32'h03E0_0008;
  localparam logic [31:0] I_JALR    = 32'h0060_F809;
  localparam logic [31:0] I_MOVZ    = 32'h0000_000A;
  localparam logic [31:0] I_BGEZAL  = 32'h0411_0004;
  localparam logic [31:0] I_BGEZ    = 32'h0401_0004;
  localparam logic [31:0] I_BLTZ    = 32'h0400_FFFE;
  localparam logic [31:0] I_J       = 32'h0800_0C00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference transfer decision for the word in D.
  task automatic model_xfer(input logic [31:0] ins, input logic [31:0] pcd,
                            input logic cmp, input logic [31:0] rs,
                            output logic redir, output logic [31:0] tgt);
    redir = 1'b0;
    tgt   = 32'h0;
    casez (ins)
      32'b000100_?????_?????_????????????????,
      32'b000001_?????_10001_????????????????,
      32'b000001_?????_00000_????????????????: begin
        redir = cmp;
        tgt   = pcd + 32'd4 + (32'(signed'(ins[15:0])) << 2);
      end
      32'b00001?_?????_?????_????????????????: begin
        redir = 1'b1;
        tgt   = {pcd[31:28], ins[25:0], 2'b00};
      end
      32'b000000_?????_?????_?????_?????_00100?: begin
        redir = 1'b1;
        tgt   = rs;
      end
      default: ;
    endcase
  endtask

  // One cycle: drive inputs, check redirect, predict, clock, compare.
  task automatic step(input logic rst_n, input logic stl, input logic [31:0] ins,
                      input logic cmp, input logic [31:0] rs);
    logic        redir;
    logic [31:0] tgt;
    exp_t        e;
    exp_t        got;
    @(negedge clk);
    reset   = rst_n;
    stall   = stl;
    instr_f = ins;
    cmpout  = cmp;
    rs_d    = rs;
    #1;
    if (m_valid) begin
      model_xfer(m_instr, m_pcd, cmp, rs, redir, tgt);
      chk("redirect", {31'h0, redirect}, {31'h0, redir});
    end else begin
      redir = 1'b0;
      tgt   = 32'h0;
    end
    if (!rst_n) begin
      m_pc = 32'h0000_3000; m_instr = 32'h0; m_pcd = 32'h0; m_pc8 = 32'h0;
      m_valid = 1;
    end else if (!stl) begin
      m_pcd = m_pc;
      m_pc8 = m_pc + 32'd8;
`ifdef NPC_DELAY_SLOT_EN
      m_instr = ins;
`else
      m_instr = redir ? 32'h0 : ins;
`endif
      m_pc = redir ? tgt : m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc8 = m_pc8;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("pc_f",    pc_f,    got.pc);
      chk("instr_d", instr_d, got.instr);
      chk("pc_d",    pc_d,    got.pcd);
      chk("pc8_d",   pc8_d,   got.pc8);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; instr_f = 32'h0; cmpout = 1'b0; rs_d = 32'h0;
    // reset held two edges with stall high
    step(0, 1, 32'h0, 0, 32'h0);
    step(0, 1, 32'h0, 0, 32'h0);
    chk("rst_pc_f", pc_f, 32'h0000_3000);
    // sequential fetch
    step(1, 0, 32'h2001_0001, 0, 32'h0);
    chk("first_pc_f", pc_f, 32'h0000_3004);
    chk("first_pc_d", pc_d, 32'h0000_3000);
    step(1, 0, 32'h2002_0002, 0, 32'h0);
    step(1, 0, I_BEQ_M1,      0, 32'h0);
    // beq -1 taken at 3008 -> 3008
    step(1, 0, 32'h2003_0003, 1, 32'h0);
    chk("beq_tgt", pc_f, 32'h0000_3008);
    step(1, 0, I_BEQ_M1,      0, 32'h0);
    // beq not taken
    step(1, 0, 32'h2003_0003, 0, 32'h0);
    chk("beq_nt", pc_f, 32'h0000_3010);
    step(1, 0, I_JAL,         0, 32'h0);
    chk("jal_pc8", pc8_d, 32'h0000_3018);
    step(1, 0, 32'h2004_0004, 0, 32'h0);
    chk("jal_tgt", pc_f, 32'h0000_3100);
    // jr under a two-cycle stall
    step(1, 0, I_JR,          0, 32'h0);
    step(1, 1, 32'h2005_0005, 0, 32'h0000_3100);
    step(1, 1, 32'h2005_0005, 0, 32'h0000_3100);
    step(1, 0, 32'h2005_0005, 0, 32'h0000_3100);
    chk("jr_tgt", pc_f, 32'h0000_3100);
    // movz is not a transfer even with cmpout high
    step(1, 0, I_MOVZ,        1, 32'h0);
    step(1, 0, I_JR,          1, 32'h1234_5678);
    // jr to top of memory, then wrap
    step(1, 0, 32'h2006_0006, 0, 32'hFFFF_FFFC);
    step(1, 0, 32'h2007_0007, 0, 32'h0);
    chk("wrap_pc_f", pc_f, 32'h0000_0000);
    step(1, 0, I_JALR,        0, 32'h0);
    step(1, 0, 32'h2008_0008, 0, 32'h0000_3000);
    // regimm forms
    step(1, 0, I_BGEZAL,      0, 32'h0);
    step(1, 0, 32'h2009_0009, 1, 32'h0);
    step(1, 0, I_BLTZ,        0, 32'h0);
    step(1, 0, 32'h200A_000A, 1, 32'h0);
    step(1, 0, I_BGEZ,        0, 32'h0);
    step(1, 0, 32'h200B_000B, 1, 32'h0);
    step(1, 0, I_J,           0, 32'h0);
    step(1, 0, 32'h200C_000C, 0, 32'h0);
    // j held in D under stall, then mid-stream reset beats both
    step(1, 0, I_J,           0, 32'h0);
    step(1, 1, 32'h200D_000D, 0, 32'h0);
    step(0, 1, 32'h200D_000D, 1, 32'h0);
    chk("midrst_instr_d", instr_d, 32'h0);
    step(1, 0, 32'h200E_000E, 0, 32'h0);
    step(1, 0, 32'h200F_000F, 0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
